vending_credit_controller: RTL and testbench

VENDING_CREDIT_CONTROLLER -- requirements
Module: vending_credit_controller

---
 rtl/vending_credit_controller_if.sv | 26 ++
 rtl/vending_credit_controller.sv | 167 ++++++++++++++++
 tb/tb_vending_credit_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vending_credit_controller_if.sv
// Coin/selection inputs and vend/refund/display outputs of the vending credit controller.
// The bench drives through master; the controller sits on slave.
interface vending_credit_controller_if;
  logic       coinValid;
  logic [1:0] coinValue;
  logic       selectValid;
  logic [1:0] selectItem;
  logic       cancel;
  logic [3:0] binaryNumber;
  logic       isError;
  logic       dispense;
  logic [1:0] dispenseItem;
  logic       changeValid;
  logic [3:0] change;
  logic       coinReject;

  modport master (
    output coinValid, coinValue, selectValid, selectItem, cancel,
    input  binaryNumber, isError, dispense, dispenseItem, changeValid, change, coinReject
  );

  modport slave (
    input  coinValid, coinValue, selectValid, selectItem, cancel,
    output binaryNumber, isError, dispense, dispenseItem, changeValid, change, coinReject
  );
endinterface

// File: rtl/vending_credit_controller.sv
// Credit-based vending controller: accepts coins, vends items against stored credit,
// refunds the remainder and flags errors for a fixed hold time. All outputs registered.
module vending_credit_controller #(
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 5,
  parameter int PRICE2     = 7,
  parameter int PRICE3     = 12,
  parameter int ERROR_HOLD = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  vending_credit_controller_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CREDIT   = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    ERROR    = 3'd4
  } state_t;

  // The counter is loaded with HOLD-1 so that isError is high for exactly HOLD cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(ERROR_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [7:0] errCnt_q, errCnt_d;
  logic       isError_q, isError_d;
  logic       dispense_q, dispense_d;
  logic [1:0] item_q, item_d;
  logic       changeValid_q, changeValid_d;
  logic [3:0] change_q, change_d;
  logic       coinReject_q, coinReject_d;

  logic [3:0] coinUnits;
  logic [4:0] coinSum;
  logic [3:0] price;

  always_comb begin
    coinUnits = 4'd1;
    case (bus.coinValue)
      2'b00:   coinUnits = 4'd1;
      2'b01:   coinUnits = 4'd2;
      2'b10:   coinUnits = 4'd5;
      default: coinUnits = 4'd10;
    endcase
  end

  always_comb begin
    price = 4'(PRICE0);
    case (bus.selectItem)
      2'd0:    price = 4'(PRICE0);
      2'd1:    price = 4'(PRICE1);
      2'd2:    price = 4'(PRICE2);
      default: price = 4'(PRICE3);
    endcase
  end

  // Sum is one bit wider than credit so an overflowing coin is detected, never wrapped.
  assign coinSum = {1'b0, credit_q} + {1'b0, coinUnits};

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    errCnt_d      = errCnt_q;
    isError_d     = 1'b0;
    dispense_d    = 1'b0;
    item_d        = 2'd0;
    changeValid_d = 1'b0;
    change_d      = 4'd0;
    coinReject_d  = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        if (bus.cancel) begin
          coinReject_d = bus.coinValid;
          if (credit_q != 4'd0) begin
            state_d       = CHANGE;
            changeValid_d = 1'b1;
            change_d      = credit_q;
          end
        end else if (bus.selectValid) begin
          coinReject_d = bus.coinValid;
          if (credit_q >= price) begin
            credit_d   = credit_q - price;
            state_d    = DISPENSE;
            dispense_d = 1'b1;
            item_d     = bus.selectItem;
          end else begin
            state_d   = ERROR;
            isError_d = 1'b1;
            errCnt_d  = HOLD_LOAD;
          end
        end else if (bus.coinValid) begin
          if (coinSum <= 5'd15) begin
            credit_d = coinSum[3:0];
            state_d  = CREDIT;
          end else begin
            coinReject_d = 1'b1;
            state_d      = ERROR;
            isError_d    = 1'b1;
            errCnt_d     = HOLD_LOAD;
          end
        end
      end
      DISPENSE: begin
        coinReject_d = bus.coinValid;
        if (credit_q != 4'd0) begin
          state_d       = CHANGE;
          changeValid_d = 1'b1;
          change_d      = credit_q;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coinReject_d = bus.coinValid;
        credit_d     = 4'd0;
        state_d      = IDLE;
      end
      ERROR: begin
        coinReject_d = bus.coinValid;
        if (errCnt_q == 8'd0) begin
          state_d = (credit_q != 4'd0) ? CREDIT : IDLE;
        end else begin
          errCnt_d  = errCnt_q - 8'd1;
          isError_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      credit_q      <= 4'd0;
      errCnt_q      <= 8'd0;
      isError_q     <= 1'b0;
      dispense_q    <= 1'b0;
      item_q        <= 2'd0;
      changeValid_q <= 1'b0;
      change_q      <= 4'd0;
      coinReject_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      errCnt_q      <= errCnt_d;
      isError_q     <= isError_d;
      dispense_q    <= dispense_d;
      item_q        <= item_d;
      changeValid_q <= changeValid_d;
      change_q      <= change_d;
      coinReject_q  <= coinReject_d;
    end
  end

  assign bus.binaryNumber = credit_q;
  assign bus.isError      = isError_q;
  assign bus.dispense     = dispense_q;
  assign bus.dispenseItem = item_q;
  assign bus.changeValid  = changeValid_q;
  assign bus.change       = change_q;
  assign bus.coinReject   = coinReject_q;

endmodule

// File: tb/tb_vending_credit_controller.sv
// Bench for vending_credit_controller: directed scenarios plus random traffic,
// all checked against a transaction-level model of credit, vend, refund and error hold.
module tb_vending_credit_controller;

  localparam int P0   = 3;
  localparam int P1   = 5;
  localparam int P2   = 7;
  localparam int P3   = 12;
  localparam int HOLD = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  vending_credit_controller_if bus ();

  vending_credit_controller #(
    .PRICE0(P0), .PRICE1(P1), .PRICE2(P2), .PRICE3(P3), .ERROR_HOLD(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int prices [4] = '{P0, P1, P2, P3};

  // Model: credit, remaining error cycles, and whether a vend or refund is being shown.
  int mCredit;
  int mErrLeft;
  int mItem;
  bit mVend;
  bit mRefund;
  bit mReject;

  function automatic int units(input logic [1:0] v);
    case (v)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 5;
      default: return 10;
    endcase
  endfunction

  task automatic modelReset();
    mCredit  = 0;
    mErrLeft = 0;
    mItem    = 0;
    mVend    = 0;
    mRefund  = 0;
    mReject  = 0;
  endtask

  task automatic modelStep(input bit cv, input logic [1:0] val, input bit sv,
                           input logic [1:0] it, input bit cn);
    mReject = 0;
    if (mRefund) begin
      mRefund = 0;
      mCredit = 0;
      mReject = cv;
    end else if (mVend) begin
      mVend   = 0;
      mRefund = (mCredit > 0);
      mReject = cv;
    end else if (mErrLeft > 0) begin
      mErrLeft = mErrLeft - 1;
      mReject  = cv;
    end else if (cn) begin
      mReject = cv;
      mRefund = (mCredit > 0);
    end else if (sv) begin
      mReject = cv;
      if (mCredit >= prices[it]) begin
        mCredit = mCredit - prices[it];
        mVend   = 1;
        mItem   = int'(it);
      end else begin
        mErrLeft = HOLD;
      end
    end else if (cv) begin
      if (mCredit + units(val) <= 15) begin
        mCredit = mCredit + units(val);
      end else begin
        mReject  = 1;
        mErrLeft = HOLD;
      end
    end
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".binaryNumber"}, 32'(bus.binaryNumber), 32'(mCredit));
    check1({tag, ".isError"},      32'(bus.isError),      32'(mErrLeft > 0));
    check1({tag, ".dispense"},     32'(bus.dispense),     32'(mVend));
    check1({tag, ".dispenseItem"}, 32'(bus.dispenseItem), mVend ? 32'(mItem) : 32'd0);
    check1({tag, ".changeValid"},  32'(bus.changeValid),  32'(mRefund));
    check1({tag, ".change"},       32'(bus.change),       mRefund ? 32'(mCredit) : 32'd0);
    check1({tag, ".coinReject"},   32'(bus.coinReject),   32'(mReject));
  endtask

  task automatic applyStimulus(input bit cv, input logic [1:0] val, input bit sv,
                               input logic [1:0] it, input bit cn, input string tag);
    @(negedge clock);
    bus.coinValid   = cv;
    bus.coinValue   = val;
    bus.selectValid = sv;
    bus.selectItem  = it;
    bus.cancel      = cn;
    @(posedge clock);
    modelStep(cv, val, sv, it, cn);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, tag);
  endtask

  task automatic pulseReset(input string tag);
    @(negedge clock);
    bus.coinValid   = 1'b0;
    bus.selectValid = 1'b0;
    bus.cancel      = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".async"});
    @(posedge clock);
    #1;
    checkOutput({tag, ".held"});
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    bus.coinValid   = 1'b0;
    bus.coinValue   = 2'b00;
    bus.selectValid = 1'b0;
    bus.selectItem  = 2'd0;
    bus.cancel      = 1'b0;
    modelReset();

    #12;
    checkOutput("reset");
    @(negedge clock);
    reset = 1'b1;

    // Coins 5 then 2, select item 1, refund of 2, back to zero.
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0, 1'b0, "s1.coin5");
    check1("s1.credit5", 32'(bus.binaryNumber), 32'd5);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'd0, 1'b0, "s1.coin2");
    check1("s1.credit7", 32'(bus.binaryNumber), 32'd7);
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd1, 1'b0, "s1.sel1");
    check1("s1.dispense", 32'(bus.dispense), 32'd1);
    check1("s1.item", 32'(bus.dispenseItem), 32'd1);
    idleCycle("s1.change");
    check1("s1.changeValid", 32'(bus.changeValid), 32'd1);
    check1("s1.change2", 32'(bus.change), 32'd2);
    idleCycle("s1.idle");
    check1("s1.zero", 32'(bus.binaryNumber), 32'd0);

    // Credit 10 plus coin 10 overflows: reject and hold error, credit kept.
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0, 1'b0, "s2.coin10");
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0, 1'b0, "s2.overflow");
    check1("s2.reject", 32'(bus.coinReject), 32'd1);
    for (int i = 0; i < HOLD + 1; i++) idleCycle("s2.hold");
    check1("s2.errorDone", 32'(bus.isError), 32'd0);
    check1("s2.credit10", 32'(bus.binaryNumber), 32'd10);
    applyStimulus(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, "s2.cancel");
    idleCycle("s2.idle");

    // Credit 2, select item 3 with too little credit.
    applyStimulus(1'b1, 2'b01, 1'b0, 2'd0, 1'b0, "s3.coin2");
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, "s3.sel3");
    check1("s3.isError", 32'(bus.isError), 32'd1);
    for (int i = 0; i < HOLD; i++) idleCycle("s3.hold");
    check1("s3.credit2", 32'(bus.binaryNumber), 32'd2);

    // Top up to 7, then cancel, select and coin together.
    applyStimulus(1'b1, 2'b10, 1'b0, 2'd0, 1'b0, "s4.coin5");
    applyStimulus(1'b1, 2'b00, 1'b1, 2'd0, 1'b1, "s4.all");
    check1("s4.change7", 32'(bus.change), 32'd7);
    check1("s4.noDispense", 32'(bus.dispense), 32'd0);
    idleCycle("s4.idle");

    // Exact-price vend: no refund pulse afterwards.
    applyStimulus(1'b1, 2'b11, 1'b0, 2'd0, 1'b0, "s5.coin10");
    applyStimulus(1'b1, 2'b01, 1'b0, 2'd0, 1'b0, "s5.coin2");
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, "s5.sel3");
    idleCycle("s5.after");
    check1("s5.noChange", 32'(bus.changeValid), 32'd0);
    idleCycle("s5.idle");

    // Reset during error.
    applyStimulus(1'b1, 2'b00, 1'b0, 2'd0, 1'b0, "s6.coin1");
    applyStimulus(1'b0, 2'b00, 1'b1, 2'd2, 1'b0, "s6.sel2");
    idleCycle("s6.err");
    pulseReset("s6.rst");
    idleCycle("s6.resume");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit cv, sv, cn;
      logic [1:0] val, it;
      cv  = ($urandom_range(0, 99) < 55);
      sv  = ($urandom_range(0, 99) < 25);
      cn  = ($urandom_range(0, 99) < 8);
      val = 2'($urandom_range(0, 3));
      it  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) pulseReset("rnd.rst");
      else applyStimulus(cv, val, sv, it, cn, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
